// File: rtl/instruction_fetch.sv
// instruction_fetch: IF stage with loadable instruction memory, step/stall control, jump redirect and sticky halt
// Ports: i_clk clock; i_reset sync active-low reset; i_step fetch enable; i_stall hold;
//        i_jump_en/i_jump_addr redirect; i_load_en/i_load_addr/i_load_data program load;
//        o_instruction/o_pc_plus4 IF/ID register; o_pc current PC; o_halt sticky halt flag
module instruction_fetch #(
   parameter int NB = 32,
   parameter int ADDR_NB = 8,
   parameter logic [NB-1:0] HALT_WORD = 32'hFFFF_FFFF
) (
   input  logic               i_clk,
   input  logic               i_reset,
   input  logic               i_step,
   input  logic               i_stall,
   input  logic               i_jump_en,
   input  logic [NB-1:0]      i_jump_addr,
   input  logic               i_load_en,
   input  logic [ADDR_NB-1:0] i_load_addr,
   input  logic [NB-1:0]      i_load_data,
   output logic [NB-1:0]      o_instruction,
   output logic [NB-1:0]      o_pc_plus4,
   output logic [NB-1:0]      o_pc,
   output logic               o_halt
);
   logic [NB-1:0] mem [2**ADDR_NB];
   logic [NB-1:0] pc;
   logic [NB-1:0] word;
   logic          fetch;
   assign word  = mem[pc[ADDR_NB+1:2]];
   assign fetch = i_reset && !i_load_en && !o_halt && i_step && !i_stall;
   assign o_pc  = pc;
   // memory survives reset, but a load coinciding with reset is dropped
   always_ff @(posedge i_clk)
      if (i_reset && i_load_en) mem[i_load_addr] <= i_load_data;
   always_ff @(posedge i_clk) begin
      if (!i_reset) begin
         pc            <= '0;
         o_instruction <= '0;
         o_pc_plus4    <= '0;
         o_halt        <= 1'b0;
      end else if (fetch) begin
         if (i_jump_en) begin
            pc            <= i_jump_addr;
            o_instruction <= '0;
            o_pc_plus4    <= '0;
         end else begin
            o_instruction <= word;
            o_pc_plus4    <= pc + NB'(4);
            // halting parks the PC on the halt word itself
            if (word == HALT_WORD) o_halt <= 1'b1;
            else pc <= pc + NB'(4);
         end
      end
   end
endmodule

// File: tb/tb_instruction_fetch.sv
// tb_instruction_fetch: directed plus randomized checks of instruction_fetch against a behavioural model
module tb_instruction_fetch;
   localparam logic [31:0] HALT = 32'hFFFF_FFFF;
   logic        clk = 1'b0;
   logic        rst_n, step, stall, jmp, ld;
   logic [31:0] jaddr, ldata;
   logic [7:0]  laddr;
   logic [31:0] o_instruction, o_pc_plus4, o_pc;
   logic        o_halt;
   logic [31:0] m_mem [256];
   logic [31:0] m_pc, m_ins, m_p4;
   logic        m_halt;
   int          checks = 0;
   int          fails = 0;

   instruction_fetch dut (
      .i_clk(clk), .i_reset(rst_n), .i_step(step), .i_stall(stall),
      .i_jump_en(jmp), .i_jump_addr(jaddr), .i_load_en(ld), .i_load_addr(laddr),
      .i_load_data(ldata), .o_instruction(o_instruction), .o_pc_plus4(o_pc_plus4),
      .o_pc(o_pc), .o_halt(o_halt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         fails++;
         $error("FAIL %s observed=%h expected=%h", tag, got, exp);
      end
   endtask

   // Reference: the memory is an array indexed by (pc/4) mod 256; control follows the priority rules.
   task automatic model(input logic r, input logic l, input logic [7:0] la, input logic [31:0] ld_d,
                        input logic s, input logic st, input logic j, input logic [31:0] ja);
      logic [31:0] w;
      if (!r) begin
         m_pc = 0; m_ins = 0; m_p4 = 0; m_halt = 0;
      end else if (l) begin
         m_mem[la] = ld_d;
      end else if (!m_halt && s && !st) begin
         w = m_mem[(m_pc / 4) % 256];
         if (j) begin
            m_pc = ja; m_ins = 0; m_p4 = 0;
         end else begin
            m_ins = w;
            m_p4 = m_pc + 4;
            if (w == HALT) m_halt = 1;
            else m_pc = m_pc + 4;
         end
      end
   endtask

   task automatic cyc(input string tag, input logic r, input logic l, input logic [7:0] la,
                      input logic [31:0] ld_d, input logic s, input logic st, input logic j,
                      input logic [31:0] ja);
      rst_n = r; ld = l; laddr = la; ldata = ld_d; step = s; stall = st; jmp = j; jaddr = ja;
      @(posedge clk);
      model(r, l, la, ld_d, s, st, j, ja);
      @(negedge clk);
      chk({tag, ".pc"}, o_pc, m_pc);
      chk({tag, ".ins"}, o_instruction, m_ins);
      chk({tag, ".p4"}, o_pc_plus4, m_p4);
      chk({tag, ".halt"}, {31'b0, o_halt}, {31'b0, m_halt});
   endtask

   task automatic run(input string tag, input logic s, input logic st) ;
      cyc(tag, 1, 0, 0, 0, s, st, 0, 0);
   endtask

   function automatic logic [31:0] rnd_word();
      logic [31:0] w;
      w = $urandom;
      return (w == HALT) ? 32'h0 : w;
   endfunction

   initial begin
      logic [31:0] prog [4];
      logic [31:0] ep4 [4];
      logic [31:0] epc [4];
      logic [31:0] held;
      prog[0] = 32'h2001_0005; prog[1] = 32'h2002_0007; prog[2] = 32'h0022_1820; prog[3] = HALT;
      ep4[0] = 4; ep4[1] = 8; ep4[2] = 12; ep4[3] = 16;
      epc[0] = 4; epc[1] = 8; epc[2] = 12; epc[3] = 12;
      for (int i = 0; i < 256; i++) m_mem[i] = 'x;
      rst_n = 1; ld = 0; laddr = 0; ldata = 0; step = 0; stall = 0; jmp = 0; jaddr = 0;
      @(negedge clk);
      cyc("reset0", 0, 0, 0, 0, 0, 0, 0, 0);
      chk("reset0.pc_zero", o_pc, 32'h0);
      for (int i = 0; i < 256; i++)
         cyc("load", 1, 1, 8'(i), (i < 4) ? prog[i] : rnd_word(), 1, 0, 0, 0);

      // straight-line program ending on a halt word
      cyc("reset1", 0, 0, 0, 0, 0, 0, 0, 0);
      for (int i = 0; i < 4; i++) begin
         run("prog", 1, 0);
         chk("prog.ins_const", o_instruction, prog[i]);
         chk("prog.p4_const", o_pc_plus4, ep4[i]);
         chk("prog.pc_const", o_pc, epc[i]);
         chk("prog.halt_const", {31'b0, o_halt}, (i == 3) ? 32'h1 : 32'h0);
      end
      run("halted", 1, 0);
      run("halted", 1, 0);
      chk("halted.pc_const", o_pc, 32'd12);

      // step low freezes everything; resume takes the next word
      cyc("reset2", 0, 0, 0, 0, 0, 0, 0, 0);
      run("step", 1, 0);
      for (int i = 0; i < 3; i++) run("nostep", 0, 0);
      chk("nostep.ins_const", o_instruction, prog[0]);
      chk("nostep.pc_const", o_pc, 32'd4);
      run("resume", 1, 0);
      chk("resume.ins_const", o_instruction, prog[1]);

      // stall at pc=8, then word 2 fetched exactly once
      cyc("reset3", 0, 0, 0, 0, 0, 0, 0, 0);
      run("s", 1, 0);
      run("s", 1, 0);
      held = o_instruction;
      for (int i = 0; i < 2; i++) begin
         run("stall", 1, 1);
         chk("stall.pc_const", o_pc, 32'd8);
         chk("stall.ins_held", o_instruction, held);
      end
      run("unstall", 1, 0);
      chk("unstall.ins_const", o_instruction, prog[2]);
      chk("unstall.pc_const", o_pc, 32'd12);

      // jump at pc=4 inserts a bubble, then fetches word 16
      cyc("reset4", 0, 0, 0, 0, 0, 0, 0, 0);
      run("j", 1, 0);
      cyc("jump", 1, 0, 0, 0, 1, 0, 1, 32'h40);
      chk("jump.ins_bubble", o_instruction, 32'h0);
      chk("jump.pc_const", o_pc, 32'h40);
      run("after_jump", 1, 0);
      chk("after_jump.ins_mem16", o_instruction, m_mem[16]);
      chk("after_jump.p4_const", o_pc_plus4, 32'h44);

      // reset beats load and jump; then wrap at the top of the address space
      cyc("reset_ovr", 0, 1, 0, 32'hDEAD_BEEF, 1, 0, 1, 32'h80);
      chk("reset_ovr.pc_const", o_pc, 32'h0);
      run("post_ovr", 1, 0);
      chk("post_ovr.ins_const", o_instruction, prog[0]);
      cyc("to_top", 1, 0, 0, 0, 1, 0, 1, 32'hFFFF_FFFC);
      run("wrap", 1, 0);
      chk("wrap.pc_const", o_pc, 32'h0);
      chk("wrap.ins_mem255", o_instruction, m_mem[255]);

      // random mix: mostly stepping, occasional stall/jump/load/reset
      for (int i = 0; i < 400; i++) begin
         logic r, l, s, st, j;
         r  = ($urandom_range(0, 49) != 0);
         l  = ($urandom_range(0, 9) == 0);
         s  = ($urandom_range(0, 4) != 0);
         st = ($urandom_range(0, 5) == 0);
         j  = ($urandom_range(0, 7) == 0);
         cyc("rand", r, l, 8'($urandom), ($urandom_range(0, 15) == 0) ? HALT : rnd_word(),
             s, st, j, $urandom);
      end

      $display("%0d/%0d checks passed", checks - fails, checks);
      $finish;
   end
endmodule
